// File: rtl/uart_rx_nbytes_sampler.sv
// 8N1 UART receiver driven by an external OVS x baud tick.
// Assembles Nbytes consecutive bytes into one word, with a valid pulse and a framing-error pulse.
module uart_rx_nbytes_sampler #(
  parameter int Nbytes = 1,
  parameter int OVS    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_en,
  input  logic                rx_lane,
  output logic [Nbytes*8-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_frame_err,
  output logic                rx_busy
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(Nbytes + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(Nbytes - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t              state_q;
  logic [1:0]          sync_q;
  logic                rxs;
  logic [TW-1:0]       tick_q;
  logic [2:0]          bit_q;
  logic [BW-1:0]       idx_q;
  logic [7:0]          shift_q;
  logic [Nbytes*8-1:0] stage_q;
  logic [Nbytes*8-1:0] stage_d;
  logic [Nbytes*8-1:0] data_q;
  logic                valid_q;
  logic                ferr_q;
  logic                busy_q;

  assign rxs = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_lane};
  end

  // Staging word with the byte just completed dropped into its slot.
  always_comb begin
    stage_d = stage_q;
    stage_d[int'(idx_q)*8 +: 8] = shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      stage_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (rx_en) begin
        unique case (state_q)
          IDLE: begin
            if (!rxs) begin
              state_q <= START;
              tick_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (tick_q == TICK_MID) begin
              tick_q <= '0;
              if (!rxs) begin
                state_q <= DATA;
                bit_q   <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          DATA: begin
            if (tick_q == TICK_END) begin
              tick_q  <= '0;
              shift_q <= {rxs, shift_q[7:1]};
              bit_q   <= bit_q + 1'b1;
              if (bit_q == 3'd7) state_q <= STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          STOP: begin
            if (tick_q == TICK_END) begin
              tick_q <= '0;
              if (rxs) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                if (idx_q == LAST_IDX) begin
                  data_q  <= stage_d;
                  valid_q <= 1'b1;
                  idx_q   <= '0;
                end else begin
                  stage_q <= stage_d;
                  idx_q   <= idx_q + 1'b1;
                end
              end else begin
                // Bad stop bit: drop the partial word and wait out the break.
                state_q <= WAIT_HIGH;
                ferr_q  <= 1'b1;
                idx_q   <= '0;
                stage_q <= '0;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          WAIT_HIGH: begin
            if (rxs) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_nbytes_sampler.sv
// Directed bench: one 1-byte and one 2-byte receiver, fed from separate serial lanes.
module tb_uart_rx_nbytes_sampler;
  localparam int OVS = 16;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        rx_en = 1'b0;
  logic        lane1 = 1'b0;
  logic        lane2 = 1'b0;
  logic [7:0]  data1;
  logic        v1, e1, b1;
  logic [15:0] data2;
  logic        v2, e2, b2;

  int n_tests = 0;
  int n_fail  = 0;
  int nv1 = 0, ne1 = 0, nv2 = 0, ne2 = 0, n_both = 0;
  logic [7:0]  cap1 = '0;
  logic [15:0] cap2 = '0;

  uart_rx_nbytes_sampler #(.Nbytes(1), .OVS(OVS)) dut1 (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx_lane(lane1),
    .rx_data(data1), .rx_valid(v1), .rx_frame_err(e1), .rx_busy(b1)
  );

  uart_rx_nbytes_sampler #(.Nbytes(2), .OVS(OVS)) dut2 (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx_lane(lane2),
    .rx_data(data2), .rx_valid(v2), .rx_frame_err(e2), .rx_busy(b2)
  );

  always #5 clk = ~clk;

  // One-clock tick every 4 clocks keeps frames short.
  initial begin : tickgen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      rx_en = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (v1) begin nv1 <= nv1 + 1; cap1 <= data1; end
    if (e1) ne1 <= ne1 + 1;
    if (v2) begin nv2 <= nv2 + 1; cap2 <= data2; end
    if (e2) ne2 <= ne2 + 1;
    if ((v1 && e1) || (v2 && e2)) n_both <= n_both + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (rx_en !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive(input int which, input logic val, input int n);
    #1;
    if (which == 1) lane1 = val;
    else            lane2 = val;
    wait_ticks(n);
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic stop);
    wait_ticks(1);
    drive(which, 1'b0, OVS);
    for (int i = 0; i < 8; i++) drive(which, b[i], OVS);
    drive(which, stop, OVS);
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'h0F;

    // Reset with lanes low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data1",  32'(data1), 32'h0);
    check("rst_valid1", 32'(v1),    32'h0);
    check("rst_ferr1",  32'(e1),    32'h0);
    check("rst_busy1",  32'(b1),    32'h0);
    check("rst_data2",  32'(data2), 32'h0);
    check("rst_valid2", 32'(v2),    32'h0);
    check("rst_ferr2",  32'(e2),    32'h0);
    check("rst_busy2",  32'(b2),    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; lane1 = 1'b1; lane2 = 1'b1;
    wait_ticks(40);
    @(negedge clk);
    check("idle_busy1",  32'(b1),  32'h0);
    check("idle_busy2",  32'(b2),  32'h0);
    check("idle_nvalid", 32'(nv1 + nv2 + ne1 + ne2), 32'h0);

    // Single byte 0xA5
    send_frame(1, 8'hA5, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("a5_nvalid", 32'(nv1),   32'd1);
    check("a5_cap",    32'(cap1),  32'hA5);
    check("a5_data",   32'(data1), 32'hA5);
    check("a5_ferr",   32'(ne1),   32'd0);
    check("a5_busy",   32'(b1),    32'h0);

    // Two-byte word 0x4F then 0x4B
    send_frame(2, 8'h4F, 1'b1);
    @(negedge clk);
    check("w2_first_nvalid", 32'(nv2),   32'd0);
    check("w2_first_data",   32'(data2), 32'h0);
    send_frame(2, 8'h4B, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("w2_nvalid", 32'(nv2),  32'd1);
    check("w2_cap",    32'(cap2), 32'h4B4F);
    check("w2_ferr",   32'(ne2),  32'd0);

    // Start-bit glitch of 4 ticks
    wait_ticks(1);
    drive(1, 1'b0, 4);
    @(negedge clk);
    check("glitch_busy_start", 32'(b1), 32'h1);
    wait_ticks(1);
    drive(1, 1'b1, 12);
    @(negedge clk);
    check("glitch_busy_end", 32'(b1),  32'h0);
    check("glitch_nvalid",   32'(nv1), 32'd1);
    check("glitch_ferr",     32'(ne1), 32'd0);

    // Framing error on 0x55, line held low for 3 bit times
    send_frame(1, 8'h55, 1'b0);
    drive(1, 1'b0, 2 * OVS);
    @(negedge clk);
    check("ferr_count",  32'(ne1),   32'd1);
    check("ferr_nvalid", 32'(nv1),   32'd1);
    check("ferr_hold",   32'(data1), 32'hA5);
    check("ferr_wait",   32'(b1),    32'h1);
    wait_ticks(1);
    drive(1, 1'b1, OVS);
    send_frame(1, 8'h33, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("after_ferr_nvalid", 32'(nv1),  32'd2);
    check("after_ferr_cap",    32'(cap1), 32'h33);
    check("after_ferr_count",  32'(ne1),  32'd1);

    // Reset during data bit 4 of 0x0F
    wait_ticks(1);
    drive(1, 1'b0, OVS);
    for (int i = 0; i < 4; i++) drive(1, partial[i], OVS);
    drive(1, partial[4], OVS / 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_busy",  32'(b1),    32'h0);
    check("midrst_data",  32'(data1), 32'h0);
    check("midrst_valid", 32'(v1),    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; lane1 = 1'b1;
    wait_ticks(OVS);
    send_frame(1, 8'hC3, 1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("c3_nvalid", 32'(nv1),   32'd3);
    check("c3_cap",    32'(cap1),  32'hC3);
    check("c3_data",   32'(data1), 32'hC3);
    check("c3_ferr",   32'(ne1),   32'd1);

    check("valid_ferr_overlap", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
